// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter funnelling packed requester transactions into one registered cache port,
// with an in-order tag FIFO that steers read data back to the requester that issued the read.
module cache_req_arbiter #(
    parameter int REQ_NUM    = 4,
    parameter int TXN_WIDTH  = 16,
    parameter int MODE_BIT   = 0,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 4,
    localparam int REQ_ID_W  = $clog2(REQ_NUM),
    localparam int PTR_W     = $clog2(RSP_DEPTH),
    localparam int CNT_W     = $clog2(RSP_DEPTH) + 1
) (
    input  logic                         aclk_i,
    input  logic                         rst_i,
    input  logic [REQ_NUM-1:0]           req_valid_i,
    input  logic [REQ_NUM*TXN_WIDTH-1:0] req_data_i,
    output logic [REQ_NUM-1:0]           req_ready_o,
    output logic                         cache_valid_o,
    output logic [TXN_WIDTH-1:0]         cache_data_o,
    input  logic                         cache_ready_i,
    input  logic                         cache_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        cache_rdata_i,
    output logic                         cache_rready_o,
    output logic [REQ_NUM-1:0]           rsp_valid_o,
    output logic [DATA_WIDTH-1:0]        rsp_data_o,
    input  logic [REQ_NUM-1:0]           rsp_ready_i,
    output logic                         err_o
);

    logic [REQ_ID_W-1:0] rr_ptr;
    logic [REQ_ID_W-1:0] grant;
    logic                grant_vld;
    logic [REQ_ID_W:0]   idx;
    logic [REQ_NUM-1:0]  eligible;
    logic [TXN_WIDTH-1:0] grant_txn;
    logic                loadable, accept, push, pop, have_tag;

    logic [REQ_ID_W-1:0] tag_mem [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    outstanding;
    logic [REQ_ID_W-1:0] head;

    // Writes never consume a tag, so only reads are gated by the outstanding limit.
    for (genvar k = 0; k < REQ_NUM; k++) begin : g_elig
        assign eligible[k] = req_valid_i[k] &&
                             (req_data_i[k*TXN_WIDTH+MODE_BIT] || outstanding < CNT_W'(RSP_DEPTH));
    end

    // Descending scan so the entry closest to rr_ptr is the last one assigned.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (REQ_ID_W+1)'(i);
            if (idx >= (REQ_ID_W+1)'(REQ_NUM))
                idx = idx - (REQ_ID_W+1)'(REQ_NUM);
            if (eligible[idx[REQ_ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx[REQ_ID_W-1:0];
            end
        end
    end

    assign loadable    = !cache_valid_o || cache_ready_i;
    assign req_ready_o = (grant_vld && loadable && !rst_i) ? (REQ_NUM'(1) << grant) : '0;
    assign accept      = |req_ready_o;
    assign grant_txn   = req_data_i[grant*TXN_WIDTH +: TXN_WIDTH];
    assign push        = accept && !grant_txn[MODE_BIT];

    assign head           = tag_mem[rd_ptr];
    assign have_tag       = outstanding != '0;
    assign rsp_data_o     = cache_rdata_i;
    assign rsp_valid_o    = (cache_rvalid_i && have_tag) ? (REQ_NUM'(1) << head) : '0;
    // With no read outstanding, stray data is drained so the cache cannot stall on it.
    assign cache_rready_o = have_tag ? rsp_ready_i[head] : 1'b1;
    assign pop            = cache_rvalid_i && have_tag && rsp_ready_i[head];

    always_ff @(posedge aclk_i) begin
        if (rst_i) begin
            cache_valid_o <= 1'b0;
            cache_data_o  <= '0;
            rr_ptr        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            err_o         <= 1'b0;
        end else begin
            if (loadable) begin
                cache_valid_o <= accept;
                if (accept)
                    cache_data_o <= grant_txn;
            end
            if (accept)
                rr_ptr <= (grant == REQ_ID_W'(REQ_NUM - 1)) ? '0 : grant + 1'b1;
            if (push) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (cache_rvalid_i && !have_tag)
                err_o <= 1'b1;
        end
    end

endmodule
